// File: rtl/btb_predictor_pkg.sv
// Shared LC-3b predictor types: BTB entry layout, direction-counter init values,
// and PC index/tag slicing helpers for any table geometry.
package lc3b_types;

  localparam int LC3B_ADDR_W  = 16;
  localparam int LC3B_ENTRIES = 16;
  localparam int LC3B_CTR_W   = 2;
  localparam int LC3B_IDX_W   = $clog2(LC3B_ENTRIES);
  localparam int LC3B_TAG_W   = LC3B_ADDR_W - LC3B_IDX_W - 1;

  // Entry layout for the default core geometry; the direction counter sits
  // alongside in its own saturating counter.
  typedef struct packed {
    logic                   valid;
    logic [LC3B_TAG_W-1:0]  tag;
    logic [LC3B_ADDR_W-1:0] target;
    logic [LC3B_CTR_W-1:0]  ctr;
  } btb_entry_t;

  function automatic logic [31:0] ctr_weak_taken(input int w);
    return 32'(1) << (w - 1);
  endfunction

  function automatic logic [31:0] ctr_weak_not_taken(input int w);
    return (32'(1) << (w - 1)) - 32'(1);
  endfunction

  // PCs are word aligned, so bit 0 never participates in index or tag.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
    return (pc >> 1) & ((32'(1) << idx_w) - 32'(1));
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
    return pc >> (idx_w + 1);
  endfunction

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// Saturating up/down counter with synchronous clear and load; holds at
// all-ones on increment and at zero on decrement.
module sat_counter #(
  parameter int             W       = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (load) begin
      value_d = load_val;
    end else if (inc && !dec) begin
      if (value_q != '1) value_d = value_q + 1'b1;
    end else if (dec && !inc) begin
      if (value_q != '0) value_d = value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= RST_VAL;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry direction counters for the
// LC-3b fetch stage, plus saturating hit/miss/mispredict statistics.
module btb_predictor
  import lc3b_types::*;
#(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              predict_hit,
  output logic              predict_taken,
  output logic [ADDR_W-1:0] predict_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              invalidate,
  input  logic              stat_clear,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_val  [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit, train_inc, train_dec, alloc;

  assign lk_idx  = IDX_W'(pc_index(32'(lookup_pc), IDX_W));
  assign lk_tag  = TAG_W'(pc_tag(32'(lookup_pc), IDX_W));
  assign upd_idx = IDX_W'(pc_index(32'(upd_pc), IDX_W));
  assign upd_tag = TAG_W'(pc_tag(32'(upd_pc), IDX_W));

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign predict_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign predict_taken  = predict_hit && ctr_val[lk_idx][CTR_W-1];
  assign predict_target = predict_hit ? target_q[lk_idx] : '0;

  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign train_inc = upd_valid && upd_hit && upd_taken;
  assign train_dec = upd_valid && upd_hit && !upd_taken;
  assign alloc     = upd_valid && !upd_hit && upd_taken;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (train_inc) target_d[upd_idx] = upd_target;
    if (alloc) begin
      valid_d[upd_idx]  = 1'b1;
      tag_d[upd_idx]    = upd_tag;
      target_d[upd_idx] = upd_target;
    end
    if (invalidate) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_dir
    logic sel;
    assign sel = (upd_idx == IDX_W'(i));
    sat_counter #(.W(CTR_W), .RST_VAL(CTR_WNT)) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (1'b0),
      .load     (alloc && sel),
      .load_val (CTR_WT),
      .inc      (train_inc && sel),
      .dec      (train_dec && sel),
      .value    (ctr_val[i])
    );
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (stat_clear),
    .load     (1'b0),
    .load_val ('0),
    .inc      (lookup_valid && predict_hit),
    .dec      (1'b0),
    .value    (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (stat_clear),
    .load     (1'b0),
    .load_val ('0),
    .inc      (lookup_valid && !predict_hit),
    .dec      (1'b0),
    .value    (miss_count)
  );

  sat_counter #(.W(CNT_W)) u_mis_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (stat_clear),
    .load     (1'b0),
    .load_val ('0),
    .inc      (upd_valid && upd_mispredict),
    .dec      (1'b0),
    .value    (mispredict_count)
  );

endmodule

// File: tb/tb_btb_predictor.sv
// Randomised and directed bench for btb_predictor against an array-based
// behavioural model of the BTB and its statistics counters.
module tb_btb_predictor;

  localparam int ADDR_W  = 16;
  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              lookup_valid, upd_valid, upd_taken, upd_mispredict;
  logic              invalidate, stat_clear;
  logic [ADDR_W-1:0] lookup_pc, upd_pc, upd_target;
  logic              predict_hit, predict_taken;
  logic [ADDR_W-1:0] predict_target;
  logic [CNT_W-1:0]  hit_count, miss_count, mispredict_count;

  int total = 0;
  int bad   = 0;

  btb_predictor #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_hit(predict_hit), .predict_taken(predict_taken), .predict_target(predict_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .invalidate(invalidate), .stat_clear(stat_clear),
    .hit_count(hit_count), .miss_count(miss_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // Reference model: one slot per index, counter kept as a plain integer.
  int mv [ENTRIES];
  int mt [ENTRIES];
  int mtg[ENTRIES];
  int mc [ENTRIES];
  int mh, mm, mmis;

  function automatic int f_idx(int pc); return (pc / 2) % ENTRIES; endfunction
  function automatic int f_tag(int pc); return pc / (2 * ENTRIES); endfunction

  function automatic logic [ADDR_W+1:0] m_lookup(int pc);
    int i = f_idx(pc);
    if (mv[i] != 0 && mt[i] == f_tag(pc)) return {1'b1, (mc[i] >= 2), 16'(mtg[i])};
    return '0;
  endfunction

  function automatic logic [3*CNT_W-1:0] m_stats();
    return {CNT_W'(mh), CNT_W'(mm), CNT_W'(mmis)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin mv[i] = 0; mc[i] = 1; end
    mh = 0; mm = 0; mmis = 0;
  endfunction

  function automatic void model_step();
    logic [ADDR_W+1:0] lk;
    int i, t;
    lk = m_lookup(int'(lookup_pc));
    if (stat_clear) begin
      mh = 0; mm = 0; mmis = 0;
    end else begin
      if (lookup_valid &&  lk[ADDR_W+1] && mh < CMAX) mh++;
      if (lookup_valid && !lk[ADDR_W+1] && mm < CMAX) mm++;
      if (upd_valid && upd_mispredict && mmis < CMAX) mmis++;
    end
    if (upd_valid) begin
      i = f_idx(int'(upd_pc));
      t = f_tag(int'(upd_pc));
      if (mv[i] != 0 && mt[i] == t) begin
        if (upd_taken) begin
          if (mc[i] < 3) mc[i]++;
          mtg[i] = int'(upd_target);
        end else if (mc[i] > 0) mc[i]--;
      end else if (upd_taken) begin
        mv[i] = 1; mt[i] = t; mtg[i] = int'(upd_target); mc[i] = 2;
      end
    end
    if (invalidate) for (int k = 0; k < ENTRIES; k++) mv[k] = 0;
  endfunction

  task automatic idle();
    lookup_valid = 0; lookup_pc = '0; upd_valid = 0; upd_pc = '0; upd_taken = 0;
    upd_target = '0; upd_mispredict = 0; invalidate = 0; stat_clear = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tg);
    idle(); upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tg;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    lookup_pc = 16'h3010;
    #12;
    total++;
    if ({predict_hit, predict_taken, predict_target} !== 18'h0) begin
      bad++; $display("FAIL reset_lookup got=%h want=0", {predict_hit, predict_taken, predict_target});
    end
    total++;
    if ({hit_count, miss_count, mispredict_count} !== '0) begin
      bad++; $display("FAIL reset_stats got=%h want=0", {hit_count, miss_count, mispredict_count});
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_allocate();
    upd(16'h3010, 1, 16'h3000);
    lookup_pc = 16'h3010; #1;
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {2'b11, 16'h3000}) begin
      bad++; $display("FAIL alloc_lookup got=%h want=%h", {predict_hit, predict_taken, predict_target}, {2'b11, 16'h3000});
    end
    total++;
    if (dut.ctr_val[8] !== 2'b10) begin
      bad++; $display("FAIL alloc_ctr got=%b want=10", dut.ctr_val[8]);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 3; n++) upd(16'h3010, 1, 16'h3000);
    total++;
    if (dut.ctr_val[8] !== 2'b11) begin
      bad++; $display("FAIL sat_up got=%b want=11", dut.ctr_val[8]);
    end
    for (int n = 0; n < 4; n++) upd(16'h3010, 0, 16'h1234);
    lookup_pc = 16'h3010; #1;
    total++;
    if ({dut.ctr_val[8], predict_hit, predict_taken, predict_target} !== {2'b00, 2'b10, 16'h3000}) begin
      bad++; $display("FAIL sat_down got=%h want=%h", {dut.ctr_val[8], predict_hit, predict_taken, predict_target}, {2'b00, 2'b10, 16'h3000});
    end
    upd(16'h3010, 0, 16'h0000);
    total++;
    if (dut.ctr_val[8] !== 2'b00) begin
      bad++; $display("FAIL sat_floor got=%b want=00", dut.ctr_val[8]);
    end
  endtask

  task automatic test_alias();
    lookup_pc = 16'h3030; #1;
    total++;
    if (predict_hit !== 1'b0) begin
      bad++; $display("FAIL alias_miss got=%b want=0", predict_hit);
    end
    upd(16'h3030, 0, 16'h4000);
    lookup_pc = 16'h3010; #1;
    total++;
    if ({predict_hit, predict_target} !== {1'b1, 16'h3000}) begin
      bad++; $display("FAIL alias_keep got=%h want=%h", {predict_hit, predict_target}, {1'b1, 16'h3000});
    end
    upd(16'h3030, 1, 16'h4000);
    lookup_pc = 16'h3010; #1;
    total++;
    if (predict_hit !== 1'b0) begin
      bad++; $display("FAIL alias_evict got=%b want=0", predict_hit);
    end
    lookup_pc = 16'h3030; #1;
    total++;
    if ({predict_hit, predict_taken, predict_target} !== {2'b11, 16'h4000}) begin
      bad++; $display("FAIL alias_new got=%h want=%h", {predict_hit, predict_taken, predict_target}, {2'b11, 16'h4000});
    end
  endtask

  task automatic test_simultaneous();
    upd(16'h3010, 1, 16'h3000);
    upd_valid = 1; upd_pc = 16'h3010; upd_taken = 1; upd_target = 16'h5000;
    lookup_valid = 1; lookup_pc = 16'h3010; #1;
    total++;
    if (predict_target !== 16'h3000) begin
      bad++; $display("FAIL same_cycle_old got=%h want=3000", predict_target);
    end
    tick();
    idle(); lookup_pc = 16'h3010; #1;
    total++;
    if (predict_target !== 16'h5000) begin
      bad++; $display("FAIL same_cycle_new got=%h want=5000", predict_target);
    end
    invalidate = 1; upd_valid = 1; upd_pc = 16'h3020; upd_taken = 1; upd_target = 16'h6000;
    tick();
    idle(); lookup_pc = 16'h3020; #1;
    total++;
    if (predict_hit !== 1'b0) begin
      bad++; $display("FAIL inval_wins got=%b want=0", predict_hit);
    end
    lookup_pc = 16'h3010; #1;
    total++;
    if (predict_hit !== 1'b0) begin
      bad++; $display("FAIL inval_all got=%b want=0", predict_hit);
    end
  endtask

  task automatic test_stats();
    idle(); stat_clear = 1; tick();
    upd(16'h3010, 1, 16'h3000);
    for (int n = 0; n < 20; n++) begin
      lookup_valid = 1; lookup_pc = 16'h3010; tick();
    end
    idle();
    total++;
    if (hit_count !== 4'd15) begin
      bad++; $display("FAIL hit_sat got=%0d want=15", hit_count);
    end
    for (int n = 0; n < 3; n++) begin
      upd_valid = 1; upd_pc = 16'h7000; upd_taken = 0; upd_mispredict = 1; tick();
    end
    idle();
    total++;
    if (mispredict_count !== 4'd3) begin
      bad++; $display("FAIL mispredict_cnt got=%0d want=3", mispredict_count);
    end
    lookup_valid = 1; lookup_pc = 16'h3010; stat_clear = 1;
    upd_valid = 1; upd_pc = 16'h7000; upd_mispredict = 1;
    tick();
    idle();
    total++;
    if ({hit_count, miss_count, mispredict_count} !== '0) begin
      bad++; $display("FAIL stat_clear got=%h want=0", {hit_count, miss_count, mispredict_count});
    end
  endtask

  task automatic test_random();
    logic [15:0] pool [6];
    pool = '{16'h3010, 16'h3030, 16'h3000, 16'h3002, 16'h4010, 16'h301e};
    for (int n = 0; n < 400; n++) begin
      lookup_valid   = 1'($urandom_range(0, 1));
      lookup_pc      = ($urandom_range(0, 7) == 0) ? 16'($urandom) : pool[$urandom_range(0, 5)];
      upd_valid      = 1'($urandom_range(0, 1));
      upd_pc         = pool[$urandom_range(0, 5)];
      upd_taken      = 1'($urandom_range(0, 1));
      upd_target     = 16'($urandom);
      upd_mispredict = 1'($urandom_range(0, 1));
      invalidate     = ($urandom_range(0, 29) == 0);
      stat_clear     = ($urandom_range(0, 39) == 0);
      #1;
      total++;
      if ({predict_hit, predict_taken, predict_target} !== m_lookup(int'(lookup_pc))) begin
        bad++; $display("FAIL rand_lookup n=%0d pc=%h got=%h want=%h", n, lookup_pc,
                        {predict_hit, predict_taken, predict_target}, m_lookup(int'(lookup_pc)));
      end
      total++;
      if ({hit_count, miss_count, mispredict_count} !== m_stats()) begin
        bad++; $display("FAIL rand_stats n=%0d got=%h want=%h", n, {hit_count, miss_count, mispredict_count}, m_stats());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    upd(16'h3010, 1, 16'h3000);
    lookup_valid = 1; lookup_pc = 16'h3010; tick();
    idle(); lookup_pc = 16'h3010;
    #3 rst_n = 0;
    model_reset();
    #1;
    total++;
    if ({predict_hit, predict_taken, predict_target} !== 18'h0) begin
      bad++; $display("FAIL midreset_lookup got=%h want=0", {predict_hit, predict_taken, predict_target});
    end
    total++;
    if ({hit_count, miss_count, mispredict_count} !== '0) begin
      bad++; $display("FAIL midreset_stats got=%h want=0", {hit_count, miss_count, mispredict_count});
    end
    #2 rst_n = 1;
    tick();
    #1;
    total++;
    if (predict_hit !== 1'b0) begin
      bad++; $display("FAIL postreset_lookup got=%b want=0", predict_hit);
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_saturation();
    test_alias();
    test_simultaneous();
    test_stats();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
Parametrised branch target buffer with per-entry saturating direction counters, the fetch-stage predictor for the pipelined LC-3b core. Fetch looks it up combinationally with the current PC; write-back resolves BR instructions and trains the table one cycle later. Adds invalidate-all and saturating hit/miss/mispredict statistics counters, readable by the counter-read path.

Parameters:
ADDR_W, 16, PC / target width in bits
ENTRIES, 16, table depth; power of two, >= 2
CTR_W, 2, direction counter width; >= 1
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
lookup_valid  in  1  fetch presents a PC this cycle
lookup_pc  in  ADDR_W  fetch PC
predict_hit  out  1  valid entry with matching tag
predict_taken  out  1  hit and counter MSB set
predict_target  out  ADDR_W  stored target; 0 when no hit
upd_valid  in  1  resolved branch this cycle
upd_pc  in  ADDR_W  PC of resolved branch
upd_taken  in  1  actual direction
upd_target  in  ADDR_W  actual target
upd_mispredict  in  1  resolution disagreed with prediction
invalidate  in  1  clear all valid bits
stat_clear  in  1  zero all statistics counters
hit_count  out  CNT_W  lookups that hit
miss_count  out  CNT_W  lookups that missed
mispredict_count  out  CNT_W  reported mispredicts

Behaviour:
- IDX_W = log2(ENTRIES); index = pc[IDX_W:1] (bit 0 ignored, word PCs); tag = pc[ADDR_W-1:IDX_W+1].
- Entry = {valid, tag, target, ctr}.
- Reset (async, rst_n low, including mid-operation): all valid = 0, ctr = weakly not-taken (MSB 0, rest 1; 01 for CTR_W=2), stats = 0. Outputs therefore read hit=0, taken=0, target=0.
- Lookup: purely combinational, 0-cycle latency; outputs are independent of lookup_valid, which gates only the stats.
- Update (registered, visible to lookups from the next cycle):
  - tag hit and upd_taken: ctr saturating +1; target <= upd_target.
  - tag hit and not taken: ctr saturating -1; target unchanged; entry stays valid.
  - miss and upd_taken: allocate by overwriting the indexed entry (direct-mapped replacement). valid=1, tag, target, ctr = weakly taken (MSB 1, rest 0; 10 for CTR_W=2).
  - miss and not taken: no change.
- Saturation: ctr holds at all-ones on +1 and at zero on -1.
- Same-cycle update and lookup to the same index: the lookup sees the pre-update contents (no bypass).
- invalidate: all valid = 0 at the edge. It wins over a same-cycle update, so no allocation survives. Counters, tags and targets are untouched.
- Statistics:
  - hit_count +1 when lookup_valid & predict_hit.
  - miss_count +1 when lookup_valid & !predict_hit.
  - mispredict_count +1 when upd_valid & upd_mispredict.
  - Each counter saturates at all-ones.
  - stat_clear zeroes all three and wins over a same-cycle increment.
- upd_mispredict does not modify the table; training relies on upd_taken/upd_target only.

Decomposition:
- Shared package (lc3b_types): btb_entry struct, counter-init constants (weak taken / weak not-taken), and the index/tag slice helpers.
- One sub-module sat_counter (parametrised width; inc/dec/clear/saturate), instantiated for each direction counter and for the three statistics counters.

Test Plan:
- Reset: pulse rst_n low mid-stream after training -> lookup 0x3010 gives hit=0, taken=0, target=0x0000; all stats = 0 without waiting for a clock edge.
- Allocate: upd pc=0x3010 taken target=0x3000 -> next cycle lookup 0x3010 gives hit=1, taken=1, target=0x3000; internal ctr=2'b10.
- Saturation: three taken updates to 0x3010 -> ctr=11. Then four not-taken -> ctr=00, hit=1, taken=0. A further not-taken leaves ctr at 00.
- Aliasing (ENTRIES=16): 0x3010 and 0x3030 share index 8 with different tags -> lookup 0x3030 misses. A not-taken update to 0x3030 leaves 0x3010 intact. A taken update to 0x3030 target 0x4000 evicts it, so 0x3010 misses.
- Simultaneous events: same-cycle taken update and lookup on 0x3010 -> old data in that cycle, new data next cycle. invalidate with a taken update in the same cycle -> next lookup misses.
- Stats (CNT_W=4): 20 hitting lookups -> hit_count=15 and holds; 3 upd_mispredict -> mispredict_count=3; stat_clear coinciding with a hit -> all counters = 0 next cycle.
